// File: rtl/fetch_stage_if.sv
// Fetch-stage signal bundle: decode-side control, instruction memory port and IF/ID outputs.
// The slave modport is the fetch stage; the master modport is its environment.
interface fetch_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        halt_commit;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  modport slave (
    input  stall, branch_taken, branch_target, halt_commit, imem_data,
    output imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted
  );

  modport master (
    output stall, branch_taken, branch_target, halt_commit, imem_data,
    input  imem_addr, if_id_instr, if_id_pc_plus2, if_id_valid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and the HLT shutdown sequence.
// Priority on each edge: branch redirect, then stall, then HLT detection, then normal advance.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic          clk,
    input logic          rst_n,
    fetch_stage_if.slave bus
);
    typedef enum logic [1:0] {RUN, HALT_PEND, HALTED} state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] instrQ;
    logic [15:0] pcPlus2Q;
    logic        validQ;
    logic        haltedQ;

    logic [15:0] pcPlus2;
    logic [15:0] redirectPc;
    logic        isHlt;

    assign pcPlus2    = pc + 16'd2;
    assign redirectPc = {bus.branch_target[15:1], 1'b0};
    assign isHlt      = (bus.imem_data[15:12] == 4'b1111);

    assign bus.imem_addr      = pc;
    assign bus.if_id_instr    = instrQ;
    assign bus.if_id_pc_plus2 = pcPlus2Q;
    assign bus.if_id_valid    = validQ;
    assign bus.halted         = haltedQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= {RESET_PC[15:1], 1'b0};
            instrQ   <= '0;
            pcPlus2Q <= '0;
            validQ   <= 1'b0;
            haltedQ  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.branch_taken) begin
                        pc     <= redirectPc;
                        instrQ <= '0;
                        validQ <= 1'b0;
                    end else if (!bus.stall) begin
                        instrQ   <= bus.imem_data;
                        pcPlus2Q <= pcPlus2;
                        validQ   <= 1'b1;
                        // HLT enters IF/ID once; PC parks on it until commit or redirect
                        if (isHlt) state <= HALT_PEND;
                        else       pc    <= pcPlus2;
                    end
                end
                HALT_PEND: begin
                    instrQ <= '0;
                    validQ <= 1'b0;
                    if (bus.branch_taken) begin
                        pc    <= redirectPc;
                        state <= RUN;
                    end else if (bus.halt_commit) begin
                        state   <= HALTED;
                        haltedQ <= 1'b1;
                    end
                end
                HALTED: begin
                end
                default: begin
                    state   <= RUN;
                    haltedQ <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized control inputs,
// compared each cycle against a flag-based behavioural model of the fetch rules.
module tb_fetch_stage;
    logic clk;
    logic rst_n;
    int unsigned testsRun;
    int unsigned testsFailed;

    fetch_stage_if bus ();
    fetch_stage #(.RESET_PC(16'h0000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [15:0] mem [0:32767];
    assign bus.imem_data = mem[bus.imem_addr[15:1]];

    // reference model state
    logic [15:0] mPc, mInstr, mPcPlus2;
    logic        mValid, mPend, mHalted;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        checkVal({tag, ".pc"}, bus.imem_addr, mPc);
        checkVal({tag, ".instr"}, bus.if_id_instr, mInstr);
        checkVal({tag, ".pcp2"}, bus.if_id_pc_plus2, mPcPlus2);
        checkVal({tag, ".valid"}, 16'(bus.if_id_valid), 16'(mValid));
        checkVal({tag, ".halted"}, 16'(bus.halted), 16'(mHalted));
    endtask

    task automatic modelReset();
        mPc = 16'h0000; mInstr = '0; mPcPlus2 = '0;
        mValid = 1'b0; mPend = 1'b0; mHalted = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkVal({tag, ".pc"}, bus.imem_addr, 16'h0000);
        checkVal({tag, ".instr"}, bus.if_id_instr, 16'h0000);
        checkVal({tag, ".pcp2"}, bus.if_id_pc_plus2, 16'h0000);
        checkVal({tag, ".valid"}, 16'(bus.if_id_valid), 16'h0000);
        checkVal({tag, ".halted"}, 16'(bus.halted), 16'h0000);
    endtask

    // entered 1 time unit after a rising edge; leaves at the same phase
    task automatic doReset(input string tag);
        #2 rst_n = 1'b0;
        #1 checkResetValues({tag, ".async"});
        modelReset();
        @(posedge clk); #1;
        checkResetValues({tag, ".held"});
        rst_n = 1'b1;
    endtask

    task automatic tick(input logic st, input logic br, input logic [15:0] tgt, input logic hc,
                        input string tag);
        logic [15:0] word;
        bus.stall = st; bus.branch_taken = br; bus.branch_target = tgt; bus.halt_commit = hc;
        if (!mHalted) begin
            if (mPend) begin
                mInstr = '0; mValid = 1'b0;
                if (br) begin
                    mPc = tgt & 16'hFFFE; mPend = 1'b0;
                end else if (hc) begin
                    mHalted = 1'b1; mPend = 1'b0;
                end
            end else if (br) begin
                mPc = tgt & 16'hFFFE; mInstr = '0; mValid = 1'b0;
            end else if (!st) begin
                word = mem[mPc >> 1];
                mInstr = word; mPcPlus2 = mPc + 16'd2; mValid = 1'b1;
                if (word >= 16'hF000) mPend = 1'b1;
                else mPc = mPc + 16'd2;
            end
        end
        @(posedge clk); #1;
        checkModel(tag);
    endtask

    task automatic fillPlain();
        for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 | 16'(i & 16'h0FFF);
    endtask

    initial begin
        testsRun = 0; testsFailed = 0;
        rst_n = 1'b0;
        bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0; bus.halt_commit = 0;
        fillPlain();
        mem[0] = 16'h0123; mem[1] = 16'h1456; mem[2] = 16'h2222; mem[3] = 16'h3333;
        mem[4] = 16'hF000;
        modelReset();
        @(posedge clk); #1;
        doReset("reset0");

        // first fetches out of reset
        tick(0, 0, '0, 0, "fetch0");
        checkVal("fetch0.const", bus.if_id_instr, 16'h0123);
        tick(0, 0, '0, 0, "fetch1");
        checkVal("fetch1.const", bus.if_id_pc_plus2, 16'h0004);
        // two stall cycles at 0x0004
        tick(1, 0, '0, 0, "stall0");
        tick(1, 0, '0, 0, "stall1");
        checkVal("stall.pc", bus.imem_addr, 16'h0004);
        tick(0, 0, '0, 0, "resume");
        checkVal("resume.instr", bus.if_id_instr, 16'h2222);
        tick(0, 0, '0, 1, "commitInRun");
        // HLT at 0x0008
        tick(0, 0, '0, 0, "hlt");
        checkVal("hlt.instr", bus.if_id_instr, 16'hF000);
        tick(0, 0, '0, 0, "pend0");
        tick(1, 0, '0, 0, "pend1");
        checkVal("pend.pc", bus.imem_addr, 16'h0008);
        tick(0, 0, '0, 1, "commit");
        checkVal("commit.halted", 16'(bus.halted), 16'h0001);
        for (int i = 0; i < 10; i++)
            tick(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), "frozen");
        doReset("resetHalted");

        // branch with stall to odd target
        fillPlain();
        for (int i = 0; i < 8; i++) tick(0, 0, '0, 0, "walk");
        checkVal("walk.pc", bus.imem_addr, 16'h0010);
        mem[16'h0018] = 16'hF123;
        tick(1, 1, 16'h0031, 0, "branchStall");
        checkVal("branchStall.pc", bus.imem_addr, 16'h0030);
        tick(0, 0, '0, 0, "hlt2");
        tick(0, 1, 16'h0040, 1, "pendBranch");
        checkVal("pendBranch.pc", bus.imem_addr, 16'h0040);
        tick(0, 0, '0, 0, "afterRedirect");
        // wrap at 0xFFFE
        tick(0, 1, 16'hFFFE, 0, "toTop");
        tick(0, 0, '0, 0, "wrap");
        checkVal("wrap.pcp2", bus.if_id_pc_plus2, 16'h0000);
        checkVal("wrap.pc", bus.imem_addr, 16'h0000);

        // randomized run
        for (int i = 0; i < 32768; i++)
            mem[i] = ($urandom_range(7) == 0) ? (16'hF000 | 16'($urandom_range(4095)))
                                              : 16'($urandom_range(16'hEFFF));
        for (int i = 0; i < 600; i++) begin
            if (mHalted && $urandom_range(3) == 0) doReset("rndReset");
            else tick($urandom_range(3) == 0, $urandom_range(6) == 0, 16'($urandom),
                      $urandom_range(4) == 0, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port stall  input  1  hold PC and IF/ID register (load-use hazard from decode).
REQ-004 SHALL have port branch_taken  input  1  resolved B/BR redirect from decode, same cycle as target.
REQ-005 SHALL have port branch_target  input  16  redirect address; bit 0 ignored.
REQ-006 SHALL have port halt_commit  input  1  pulse when the HLT instruction retires at writeback.
REQ-007 SHALL have port imem_addr  output  16  instruction memory address, equal to current PC.
REQ-008 SHALL have port imem_data  input  16  instruction word, combinational read of imem_addr.
REQ-009 SHALL have port if_id_instr  output  16  registered instruction presented to the control decoder.
REQ-010 SHALL have port if_id_pc_plus2  output  16  registered PC+2 of that instruction (PCS and branch base).
REQ-011 SHALL have port if_id_valid  output  1  registered; 0 marks a bubble.
REQ-012 SHALL have port halted  output  1  processor stopped; only reset exits.
REQ-013 SHALL have parameter RESET_PC, default 16'h0000, meaning PC value loaded at reset.

Function
REQ-014 SHALL hold PC in a 16-bit register with PC[0] always 0; imem_addr = PC combinationally.
REQ-015 SHALL compute PC+2 modulo 2^16 (16'hFFFE + 2 = 16'h0000, no carry out).
REQ-016 SHALL implement states RUN, HALT_PEND, HALTED (encoding free).
REQ-017 SHALL define HLT as imem_data[15:12] = 4'b1111.
REQ-018 SHALL define a bubble as if_id_instr = 16'h0000, if_id_valid = 0, if_id_pc_plus2 unchanged.
REQ-019 SHALL apply per-edge priority: branch_taken > stall > halt detection > normal advance.
REQ-020 RUN, branch_taken=1: PC <= {branch_target[15:1],1'b0}; IF/ID <= bubble; stay RUN (stall ignored).
REQ-021 RUN, stall=1, branch_taken=0: PC and all IF/ID outputs hold their values.
REQ-022 RUN, fetched word not HLT, no stall/branch: PC <= PC+2; IF/ID <= {imem_data, PC+2, valid=1}.
REQ-023 RUN, fetched word is HLT, no stall/branch: PC holds; IF/ID <= {HLT, PC+2, valid=1}; go HALT_PEND.
REQ-024 HALT_PEND: PC holds; IF/ID <= bubble each edge; no new instruction fetched into IF/ID.
REQ-025 HALT_PEND, branch_taken=1: PC <= target, IF/ID <= bubble, go RUN (HLT was wrong-path).
REQ-026 HALT_PEND, halt_commit=1, branch_taken=0: go HALTED.
REQ-027 HALT_PEND, branch_taken and halt_commit both 1: branch wins (REQ-025).
REQ-028 HALTED: PC, IF/ID, state frozen; all inputs except rst_n ignored; halted=1.
REQ-029 halted SHALL be a registered state decode, 1 only in HALTED.
REQ-030 halt_commit in RUN SHALL be ignored.
REQ-031 Fetch latency: instruction at PC appears on if_id_instr one edge after PC is presented.
REQ-032 Downstream SHALL gate RegWrite, MemWrite, MemRead, Flag_Enable with if_id_valid; this block guarantees valid=0 on every bubble.

Reset
REQ-033 rst_n low SHALL immediately (asynchronously) force PC=RESET_PC, state=RUN, if_id_instr=16'h0000, if_id_pc_plus2=16'h0000, if_id_valid=0, halted=0.
REQ-034 Reset asserted mid-operation (any state, including HALTED) SHALL abort all activity with no partial update.
REQ-035 First rising edge with rst_n high SHALL perform a normal RUN fetch from RESET_PC.

Verification
REQ-036 Reset then imem returns 16'h0123 at 0x0000, 16'h1456 at 0x0002 -> if_id_instr 0123/pc_plus2 0002, then 1456/0004; valid=1.
REQ-037 stall=1 for 2 cycles at PC=0x0004 -> PC and IF/ID unchanged both cycles; fetch resumes at 0x0004.
REQ-038 branch_taken=1, stall=1, target=16'h0031 at PC=0x0010 -> PC=0x0030, IF/ID bubble (valid=0, instr 0000).
REQ-039 HLT (16'hF000) at 0x0008 -> IF/ID holds HLT once, then bubbles, PC stays 0x0008; halt_commit pulse -> halted=1, frozen for 10 cycles.
REQ-040 HLT fetched, then branch_taken target 0x0040 in HALT_PEND -> state RUN, PC=0x0040, halted stays 0.
REQ-041 PC=0xFFFE fetching non-HLT -> next PC=0x0000, if_id_pc_plus2=0x0000; rst_n pulsed low in HALTED -> all outputs at reset values asynchronously.
